// File: rtl/hack_display_pkg.sv
// Shared constants for the debug register overlay: colours, cell geometry
// and the capture FSM state encoding.
package hack_display_pkg;

    localparam logic [2:0]  COL_ON     = 3'b100;
    localparam logic [2:0]  COL_OFF    = 3'b000;
    localparam logic [10:0] CELL_OFS   = 11'd11;
    localparam logic [10:0] CELL_W     = 11'd5;
    localparam logic [10:0] CELL_PITCH = 11'd10;
    localparam int          CELLS      = 16;

    // Last horizontal offset that still belongs to a row (end of cell 15).
    localparam logic [10:0] H_SPAN_END = CELL_OFS + 11'(CELLS - 1) * CELL_PITCH + CELL_W - 11'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } cap_state_t;

endpackage

// File: rtl/overlay_cell_decode.sv
// Combinational hit test for one overlay row: is the beam inside the row
// region, which of the 16 bit-cells it is over, and whether it is on the lit part.
module overlay_cell_decode
    import hack_display_pkg::*;
#(
    parameter logic [10:0] POS_H = 11'd8
) (
    input  logic [10:0] i_vga_h,
    input  logic [10:0] i_vga_v,
    input  logic [10:0] i_origin_v,
    output logic        o_hit,
    output logic [3:0]  o_cell,
    output logic        o_in_cell
);

    logic [10:0] w_v_off;
    logic [10:0] w_h_off;
    logic [10:0] w_rel;
    logic        w_v_ok;
    logic        w_h_ok;

    // Offsets only count when the beam is at or past the origin, so a small
    // counter never wraps into a huge offset that looks like a hit.
    always_comb begin
        w_v_off = i_vga_v - i_origin_v;
        w_h_off = i_vga_h - POS_H;
        w_v_ok  = (i_vga_v >= i_origin_v) && (w_v_off >= CELL_OFS) &&
                  (w_v_off <= CELL_OFS + CELL_W - 11'd1);
        w_h_ok  = (i_vga_h >= POS_H) && (w_h_off >= CELL_OFS) && (w_h_off <= H_SPAN_END);
        w_rel   = w_h_off - CELL_OFS;
    end

    assign o_hit     = w_v_ok && w_h_ok;
    assign o_cell    = 4'(w_rel / CELL_PITCH);
    assign o_in_cell = o_hit && ((w_rel % CELL_PITCH) < CELL_W);

endmodule

// File: rtl/register_overlay_ctrl.sv
// Debug register overlay: snapshots N_REGS CPU registers once per frame in
// vblank over a shared read mux, then renders each as a row of 16 bit-cells.
module register_overlay_ctrl
    import hack_display_pkg::*;
#(
    parameter int          N_REGS     = 4,
    parameter logic [10:0] POS_H      = 11'd8,
    parameter logic [10:0] POS_V      = 11'd8,
    parameter logic [10:0] ROW_PITCH  = 11'd20,
    parameter logic [10:0] CAPTURE_LN = 11'd490,
    parameter logic [2:0]  ON_COLOUR  = COL_ON,
    parameter logic [2:0]  OFF_COLOUR = COL_OFF,
    localparam int         SEL_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      vga_h,
    input  logic [10:0]      vga_v,
    input  logic [2:0]       bg,
    input  logic             freeze,
    output logic [SEL_W-1:0] reg_sel,
    input  logic [15:0]      reg_data,
    output logic             capture_busy,
    output logic [2:0]       pixel_out,
    output logic             display_on
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REGS - 1);

    cap_state_t       r_state;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] r_reg_sel;
    logic             r_busy;
    logic [15:0]      r_snap [N_REGS];

    logic             w_trigger;

    assign w_trigger    = (vga_v == CAPTURE_LN) && (vga_h == 11'd0) && !freeze;
    assign reg_sel      = r_reg_sel;
    assign capture_busy = r_busy;

    // Read data lags reg_sel by one cycle, so each ISSUE cycle stores the
    // previous slot and DRAIN picks up the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_reg_sel <= '0;
            r_busy    <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                r_snap[i] <= 16'h0000;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state   <= ST_ISSUE;
                        r_idx     <= '0;
                        r_reg_sel <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (r_idx != '0) begin
                        r_snap[r_idx - 1'b1] <= reg_data;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state   <= ST_DRAIN;
                        r_reg_sel <= '0;
                    end else begin
                        r_idx     <= r_idx + 1'b1;
                        r_reg_sel <= r_idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_snap[N_REGS-1] <= reg_data;
                    r_idx            <= '0;
                    r_state          <= ST_IDLE;
                    r_busy           <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_idx     <= '0;
                    r_reg_sel <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    logic [10:0]       w_origin [N_REGS];
    logic [N_REGS-1:0] w_hit;
    logic [N_REGS-1:0] w_in_cell;
    logic [3:0]        w_cell [N_REGS];

    for (genvar g = 0; g < N_REGS; g++) begin : g_slot
        assign w_origin[g] = POS_V + 11'(g) * ROW_PITCH;

        overlay_cell_decode #(
            .POS_H (POS_H)
        ) u_decode (
            .i_vga_h    (vga_h),
            .i_vga_v    (vga_v),
            .i_origin_v (w_origin[g]),
            .o_hit      (w_hit[g]),
            .o_cell     (w_cell[g]),
            .o_in_cell  (w_in_cell[g])
        );
    end

    logic [SEL_W-1:0] w_slot;
    logic [3:0]       w_cell_any;
    logic             w_in_cell_any;

    // Rows never overlap, so OR-merging the per-slot results is unambiguous.
    always_comb begin
        w_slot        = '0;
        w_cell_any    = '0;
        w_in_cell_any = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_hit[i]) begin
                w_slot        = w_slot | SEL_W'(i);
                w_cell_any    = w_cell_any | w_cell[i];
                w_in_cell_any = w_in_cell_any | w_in_cell[i];
            end
        end
    end

    // ---- S1: decoded position and aligned background ----
    logic             r_hit_p1;
    logic [SEL_W-1:0] r_slot_p1;
    logic [3:0]       r_cell_p1;
    logic             r_in_cell_p1;
    logic [2:0]       r_bg_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_p1     <= 1'b0;
            r_slot_p1    <= '0;
            r_cell_p1    <= '0;
            r_in_cell_p1 <= 1'b0;
            r_bg_p1      <= '0;
        end else begin
            r_hit_p1     <= |w_hit;
            r_slot_p1    <= w_slot;
            r_cell_p1    <= w_cell_any;
            r_in_cell_p1 <= w_in_cell_any;
            r_bg_p1      <= bg;
        end
    end

    // ---- S2: colour selection, registered outputs ----
    logic w_bit;

    assign w_bit = r_snap[r_slot_p1][4'd15 - r_cell_p1];

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_out  <= '0;
            display_on <= 1'b0;
        end else begin
            display_on <= r_hit_p1;
            if (r_hit_p1 && r_in_cell_p1) begin
                pixel_out <= w_bit ? ON_COLOUR : OFF_COLOUR;
            end else begin
                pixel_out <= r_bg_p1;
            end
        end
    end

endmodule

// File: tb/tb_register_overlay_ctrl.sv
// Scoreboard bench for register_overlay_ctrl: pixel expectations are queued
// when a beam position is driven and compared when they leave the pipeline.
module tb_register_overlay_ctrl;

    localparam int N      = 4;
    localparam int CAP_LN = 490;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [10:0] vga_h  = '0;
    logic [10:0] vga_v  = '0;
    logic [2:0]  bg     = '0;
    logic        freeze = 1'b0;
    logic [1:0]  reg_sel;
    logic [15:0] reg_data;
    logic        capture_busy;
    logic [2:0]  pixel_out;
    logic        display_on;

    always #5 clk = ~clk;

    register_overlay_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .vga_h        (vga_h),
        .vga_v        (vga_v),
        .bg           (bg),
        .freeze       (freeze),
        .reg_sel      (reg_sel),
        .reg_data     (reg_data),
        .capture_busy (capture_busy),
        .pixel_out    (pixel_out),
        .display_on   (display_on)
    );

    // Registered read mux of the CPU debug taps.
    logic [15:0] tbl    [N];
    logic [15:0] m_snap [N];
    always @(posedge clk) reg_data <= tbl[reg_sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [2:0] pix;
        logic       on;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference overlay renderer: returns {display_on, pixel}.
    function automatic logic [3:0] model(input int h, input int v, input logic [2:0] b);
        logic [3:0] r;
        r = {1'b0, b};
        for (int i = 0; i < N; i++) begin
            int vo;
            int ho;
            int rel;
            vo = v - (8 + 20 * i);
            ho = h - 8;
            if (vo >= 11 && vo <= 15 && ho >= 11 && ho <= 165) begin
                rel = ho - 11;
                if ((rel % 10) < 5)
                    r = {1'b1, (m_snap[i][15 - rel / 10] ? 3'b100 : 3'b000)};
                else
                    r = {1'b1, b};
            end
        end
        return r;
    endfunction

    task automatic put(input string tag, input int h, input int v, input logic [2:0] b);
        logic [3:0] e;
        exp_t       x;
        vga_h = 11'(h);
        vga_v = 11'(v);
        bg    = b;
        e     = model(h, v, b);
        x.tag = tag;
        x.pix = e[2:0];
        x.on  = e[3];
        x.due = cyc + 2;
        q.push_back(x);
    endtask

    task automatic px(input string tag, input int h, input int v, input logic [2:0] b);
        @(posedge clk);
        #1;
        put(tag, h, v, b);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            chk({mon_e.tag, ".pix"}, 16'(pixel_out), 16'(mon_e.pix));
            chk({mon_e.tag, ".on"}, 16'(display_on), 16'(mon_e.on));
        end
    end

    // Trigger a capture and follow busy/reg_sel cycle by cycle.
    task automatic cap_seq(input string tag, input bit frz);
        logic       exp_busy;
        logic [1:0] exp_sel;
        freeze = frz;
        @(posedge clk);
        #1;
        put({tag, ".trig"}, 0, CAP_LN, 3'b001);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            exp_busy = !frz && (k >= 1) && (k <= 5);
            exp_sel  = (!frz && k >= 1 && k <= 4) ? 2'(k - 1) : 2'd0;
            chk($sformatf("%s.busy%0d", tag, k), 16'(capture_busy), 16'(exp_busy));
            chk($sformatf("%s.sel%0d", tag, k), 16'(reg_sel), 16'(exp_sel));
        end
        put({tag, ".post"}, 1, CAP_LN, 3'b001);
        freeze = 1'b0;
        if (!frz)
            for (int i = 0; i < N; i++) m_snap[i] = tbl[i];
    endtask

    task automatic scan(input string tag);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 16; k++) begin
                px($sformatf("%s.s%0dc%0d", tag, i, k), 21 + 10 * k, 21 + 20 * i, 3'b010);
                px($sformatf("%s.s%0dg%0d", tag, i, k), 26 + 10 * k, 21 + 20 * i, 3'b011);
            end
        end
    endtask

    initial begin
        tbl[0] = 16'hA5F0;
        tbl[1] = 16'h1234;
        tbl[2] = 16'h8001;
        tbl[3] = 16'hFFFF;
        for (int i = 0; i < N; i++) m_snap[i] = 16'h0000;

        bg = 3'b111;
        repeat (3) begin
            @(negedge clk);
            chk("rst.pix", 16'(pixel_out), 16'd0);
            chk("rst.on", 16'(display_on), 16'd0);
            chk("rst.busy", 16'(capture_busy), 16'd0);
            chk("rst.sel", 16'(reg_sel), 16'd0);
        end
        reset = 1'b0;

        cap_seq("cap1", 1'b0);
        scan("scan1");

        tbl[0] = 16'h8001;
        cap_seq("cap2", 1'b0);
        px("r.cell0", 19, 19, 3'b000);
        px("r.cell1", 29, 19, 3'b000);
        px("r.gap0", 24, 19, 3'b010);
        px("r.bit0", 173, 19, 3'b000);
        px("r.hend", 174, 19, 3'b011);
        px("r.hout", 175, 19, 3'b011);
        px("r.hpre", 18, 19, 3'b101);
        px("r.vpre", 19, 18, 3'b101);
        px("r.vlast", 19, 23, 3'b101);
        px("r.vend", 19, 24, 3'b101);
        px("r.s1b13", 39, 39, 3'b110);
        px("r.s1out", 39, 35, 3'b101);
        px("r.s3b0", 173, 79, 3'b000);

        tbl[0] = 16'h7FFE;
        tbl[3] = 16'h0000;
        cap_seq("frz", 1'b1);
        px("frz.cell0", 19, 19, 3'b000);
        scan("scan2");

        // Abort two cycles into ISSUE; the partial capture must not survive.
        @(posedge clk);
        #1;
        put("abt.trig", 0, CAP_LN, 3'b001);
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk($sformatf("abt.busy%0d", k), 16'(capture_busy), 16'(k >= 1));
        end
        reset = 1'b1;
        vga_h = 11'd1;
        @(negedge clk);
        chk("abt.busy", 16'(capture_busy), 16'd0);
        chk("abt.sel", 16'(reg_sel), 16'd0);
        chk("abt.pix", 16'(pixel_out), 16'd0);
        chk("abt.on", 16'(display_on), 16'd0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_snap[i] = 16'h0000;
        repeat (2) @(negedge clk);
        chk("abt.idle", 16'(capture_busy), 16'd0);
        scan("scan3");

        for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        chk("drain", 16'(q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
